// File: rtl/uart_autobaud.sv
// ---------------------------------------------------------------------------
// uart_autobaud
//
// Automatic baud-rate controller. When armed it measures one 0x55 sync
// character on the raw RX line, derives the bit length in clocks, validates
// it and then drives the new bit length to uart_rx / uart_tx. While a
// measurement is in progress o_rx_hold tells the top level to discard
// whatever uart_rx produces.
//
// Optional feature (macro UART_AUTOBAUD_RETRY_EN):
//   defined   - a failed measurement goes back to GUARD and re-arms by itself
//               until it succeeds or i_abort is seen.
//   undefined - a failed measurement returns to IDLE; software re-arms.
//
// Ports:
//   i_clk               system clock
//   i_rst               synchronous active-high reset
//   i_arm               one-cycle measurement request (ignored while busy)
//   i_abort             one-cycle request to return to IDLE, no update
//   i_rx                raw asynchronous RX line
//   o_bit_length        bit length in clocks for uart_rx / uart_tx
//   o_bit_length_valid  one-cycle pulse when o_bit_length is updated
//   o_locked            set by a successful measurement, cleared by i_arm
//   o_busy              controller is not idle
//   o_rx_hold           same as o_busy; receiver output is to be discarded
//   o_timeout_err       sticky, a phase took too long; cleared by i_arm
//   o_range_err         sticky, result out of range;   cleared by i_arm
// ---------------------------------------------------------------------------
module uart_autobaud #(
    parameter logic [31:0] DEFAULT_BIT_LEN = 32'd867,
    parameter logic [31:0] MIN_BIT_LEN     = 32'd3,
    parameter logic [31:0] TIMEOUT_CLKS    = 32'd1_000_000,
    parameter logic [15:0] GUARD_CLKS      = 16'd16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_arm,
    input  logic        i_abort,
    input  logic        i_rx,
    output logic [31:0] o_bit_length,
    output logic        o_bit_length_valid,
    output logic        o_locked,
    output logic        o_busy,
    output logic        o_rx_hold,
    output logic        o_timeout_err,
    output logic        o_range_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD,
        ST_WAIT_START,
        ST_MEASURE,
        ST_WAIT_STOP,
        ST_CHECK,
        ST_APPLY,
        ST_ERROR
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_t      state_reg, state_next;

    // RX conditioning: two-flop synchronizer plus one delay flop
    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic        rx_fall, rx_rise;

    logic [31:0] phase_reg, phase_next;
    logic [15:0] guard_reg, guard_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [2:0]  edges_reg, edges_next;
    logic [31:0] t0_reg, t0_next;
    logic        t0_seen_reg, t0_seen_next;
    logic [31:0] s_reg, s_next;
    logic [31:0] bit_length_reg, bit_length_next;
    logic        valid_reg, valid_next;
    logic        locked_reg, locked_next;
    logic        timeout_err_reg, timeout_err_next;
    logic        range_err_reg, range_err_next;

    logic [31:0] cnt_inc, phase_inc;
    logic [31:0] s_plus4, calc_bl;
    logic [34:0] eight_t0, s_wide, deviation, dev_limit;
    logic        range_bad;
    logic        timed_state, timeout_hit;

    assign rx_fall = rx_prev_reg & ~rx_sync_reg;
    assign rx_rise = ~rx_prev_reg & rx_sync_reg;

    // Counters saturate so a stuck line can never wrap back into a
    // plausible value; the phase timeout always fires long before that.
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 32'd1;
    assign phase_inc = (phase_reg == CNT_MAX) ? phase_reg : phase_reg + 32'd1;

    // S spans 8 bit periods; round to nearest then subtract one because
    // uart_rx counts 0..bit_length inclusive.
    assign s_plus4 = s_reg + 32'd4;
    assign calc_bl = (s_plus4 >> 3) - 32'd1;

    // Start-bit sanity check done in 35 bits so 8*T0 cannot overflow.
    assign eight_t0  = {t0_reg, 3'b000};
    assign s_wide    = {3'b000, s_reg};
    assign deviation = (eight_t0 >= s_wide) ? (eight_t0 - s_wide) : (s_wide - eight_t0);
    assign dev_limit = {5'b00000, s_reg[31:2]};
    assign range_bad = (calc_bl < MIN_BIT_LEN) || (deviation > dev_limit);

    assign timed_state = (state_reg == ST_GUARD) || (state_reg == ST_WAIT_START) ||
                         (state_reg == ST_MEASURE) || (state_reg == ST_WAIT_STOP);
    assign timeout_hit = timed_state && (phase_reg >= TIMEOUT_CLKS);

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_inc;
        guard_next       = guard_reg;
        cnt_next         = cnt_inc;
        edges_next       = edges_reg;
        t0_next          = t0_reg;
        t0_seen_next     = t0_seen_reg;
        s_next           = s_reg;
        bit_length_next  = bit_length_reg;
        valid_next       = 1'b0;
        locked_next      = locked_reg;
        timeout_err_next = timeout_err_reg;
        range_err_next   = range_err_reg;

        if (i_abort) begin
            state_next = ST_IDLE;
        end else if (timeout_hit) begin
            timeout_err_next = 1'b1;
            state_next       = ST_ERROR;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_arm) begin
                        locked_next      = 1'b0;
                        timeout_err_next = 1'b0;
                        range_err_next   = 1'b0;
                        state_next       = ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // Need a quiet high line so we don't lock onto the
                    // middle of a character already in flight.
                    guard_next = rx_sync_reg ? guard_reg + 16'd1 : 16'd0;
                    if (guard_reg >= GUARD_CLKS) begin
                        state_next = ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (rx_fall) begin
                        cnt_next     = 32'd0;
                        edges_next   = 3'd1;
                        t0_seen_next = 1'b0;
                        state_next   = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // cnt+1 is the distance in clocks from the start edge
                    if (rx_rise && !t0_seen_reg) begin
                        t0_next      = cnt_inc;
                        t0_seen_next = 1'b1;
                    end
                    if (rx_fall) begin
                        edges_next = edges_reg + 3'd1;
                        // 5th falling edge of 0x55 sits 8 bit periods in
                        if (edges_reg == 3'd4) begin
                            s_next     = cnt_inc;
                            state_next = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    if (rx_rise) begin
                        state_next = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (range_bad) begin
                        range_err_next = 1'b1;
                        state_next     = ST_ERROR;
                    end else begin
                        state_next = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    bit_length_next = calc_bl;
                    valid_next      = 1'b1;
                    locked_next     = 1'b1;
                    state_next      = ST_IDLE;
                end
                ST_ERROR: begin
`ifdef UART_AUTOBAUD_RETRY_EN
                    state_next = ST_GUARD;
`else
                    state_next = ST_IDLE;
`endif
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Every state starts its timeout and guard window from zero
        if (state_next != state_reg) begin
            phase_next = 32'd0;
            guard_next = 16'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= ST_IDLE;
            rx_meta_reg     <= 1'b1;
            rx_sync_reg     <= 1'b1;
            rx_prev_reg     <= 1'b1;
            phase_reg       <= 32'd0;
            guard_reg       <= 16'd0;
            cnt_reg         <= 32'd0;
            edges_reg       <= 3'd0;
            t0_reg          <= 32'd0;
            t0_seen_reg     <= 1'b0;
            s_reg           <= 32'd0;
            bit_length_reg  <= DEFAULT_BIT_LEN;
            valid_reg       <= 1'b0;
            locked_reg      <= 1'b0;
            timeout_err_reg <= 1'b0;
            range_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rx_meta_reg     <= i_rx;
            rx_sync_reg     <= rx_meta_reg;
            rx_prev_reg     <= rx_sync_reg;
            phase_reg       <= phase_next;
            guard_reg       <= guard_next;
            cnt_reg         <= cnt_next;
            edges_reg       <= edges_next;
            t0_reg          <= t0_next;
            t0_seen_reg     <= t0_seen_next;
            s_reg           <= s_next;
            bit_length_reg  <= bit_length_next;
            valid_reg       <= valid_next;
            locked_reg      <= locked_next;
            timeout_err_reg <= timeout_err_next;
            range_err_reg   <= range_err_next;
        end
    end

    assign o_bit_length       = bit_length_reg;
    assign o_bit_length_valid = valid_reg;
    assign o_locked           = locked_reg;
    assign o_busy             = (state_reg != ST_IDLE);
    assign o_rx_hold          = (state_reg != ST_IDLE);
    assign o_timeout_err      = timeout_err_reg;
    assign o_range_err        = range_err_reg;

endmodule

// File: tb/tb_uart_autobaud.sv
// ---------------------------------------------------------------------------
// tb_uart_autobaud
//
// Self-checking bench for uart_autobaud. Drives 0x55 sync characters as a
// list of segment durations and predicts the result from the waveform
// itself (start-bit width and span of 8 bit periods). Works with and
// without UART_AUTOBAUD_RETRY_EN defined.
// ---------------------------------------------------------------------------
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        abort_req = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] bit_length;
    logic        bit_length_valid;
    logic        locked;
    logic        busy;
    logic        rx_hold;
    logic        timeout_err;
    logic        range_err;

    always #5 clk = ~clk;

    uart_autobaud #(
        .DEFAULT_BIT_LEN (32'd867),
        .MIN_BIT_LEN     (32'd3),
        .TIMEOUT_CLKS    (32'd1000),
        .GUARD_CLKS      (16'd16)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_arm              (arm),
        .i_abort            (abort_req),
        .i_rx               (rx),
        .o_bit_length       (bit_length),
        .o_bit_length_valid (bit_length_valid),
        .o_locked           (locked),
        .o_busy             (busy),
        .o_rx_hold          (rx_hold),
        .o_timeout_err      (timeout_err),
        .o_range_err        (range_err)
    );

    int     checks = 0;
    int     errors = 0;
    int     valid_count = 0;
    longint cur_bl = 867;
    int     durs[10];

    typedef struct {
        int     bit_clks;
        int     start_clks;
        bit     jit;
        longint exp_bl;
        bit     exp_err;
    } vec_t;

    vec_t tbl[8];

    always @(negedge clk) begin
        if (bit_length_valid) valid_count++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_arm();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort_req = 1'b1;
        @(posedge clk); #1 abort_req = 1'b0;
    endtask

    task automatic drive_seg(input logic level, input int n);
        @(posedge clk); #1 rx = level;
        repeat (n - 1) @(posedge clk);
    endtask

    // Start, b0..b7 from durs[], ends right after the stop-bit rise.
    task automatic drive_char();
        for (int k = 0; k < 9; k++) drive_seg(logic'(k % 2), durs[k]);
        @(posedge clk); #1 rx = 1'b1;
    endtask

    // Edge k sits at start + (k-1)*b, optionally jittered by one clock.
    task automatic make_durs(input int b, input int st, input bit jit);
        int e[10];
        e[0] = 0;
        for (int k = 1; k < 10; k++) begin
            e[k] = st + (k - 1) * b;
            if (jit) e[k] += int'($urandom_range(2)) - 1;
        end
        for (int k = 0; k < 9; k++) durs[k] = e[k + 1] - e[k];
        durs[9] = 0;
    endtask

    // Reference: start-bit width T0, 8-period span S, rounded bit length.
    task automatic model(output longint bl, output bit err);
        longint t0, s, d;
        t0 = durs[0];
        s  = 0;
        for (int k = 0; k < 8; k++) s += durs[k];
        bl  = ((s + 4) / 8) - 1;
        d   = (8 * t0 > s) ? (8 * t0 - s) : (s - 8 * t0);
        err = (bl < 3) || (d > s / 4);
    endtask

    task automatic wait_event(input bit valid_only, output int c, output bit found);
        found = 1'b0;
        c     = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bit_length_valid || (!valid_only && (range_err || timeout_err))) begin
                found = 1'b1;
                c     = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input int b, input int st, input bit jit,
                           input bit use_model, input longint t_bl, input bit t_err);
        longint exp_bl;
        bit     exp_err;
        int     c;
        bit     found;
        int     v0;
        make_durs(b, st, jit);
        if (use_model) model(exp_bl, exp_err);
        else begin
            exp_bl  = t_bl;
            exp_err = t_err;
        end
        v0 = valid_count;
        pulse_arm();
        drive_seg(1'b1, 30);
        drive_char();
        wait_event(1'b0, c, found);
        chk({name, "_done"}, longint'(found), 1);
        if (!exp_err) chk_range({name, "_latency"}, c, 4, 6);
        repeat (3) @(negedge clk);
        chk({name, "_bitlen"}, bit_length, exp_err ? cur_bl : exp_bl);
        chk({name, "_range"}, longint'(range_err), longint'(exp_err));
        chk({name, "_locked"}, longint'(locked), longint'(!exp_err));
        chk({name, "_tout"}, longint'(timeout_err), 0);
        chk({name, "_valid"}, valid_count - v0, exp_err ? 0 : 1);
`ifdef UART_AUTOBAUD_RETRY_EN
        chk({name, "_busy"}, longint'(busy), longint'(exp_err));
        if (exp_err) pulse_abort();
`else
        chk({name, "_busy"}, longint'(busy), 0);
`endif
        if (!exp_err) cur_bl = exp_bl;
        $display("%s bit=%0d start=%0d -> bit_length=%0d range_err=%0b (exp %0d/%0b)",
                 name, b, st, bit_length, range_err, exp_err ? cur_bl : exp_bl, exp_err);
    endtask

    initial begin
        int c;
        bit found;
        int v0;

        tbl[0] = '{16, 16, 1'b0, 15, 1'b0};
        tbl[1] = '{100, 100, 1'b1, 99, 1'b0};
        tbl[2] = '{2, 2, 1'b0, 0, 1'b1};
        tbl[3] = '{16, 24, 1'b0, 0, 1'b1};
        tbl[4] = '{4, 4, 1'b0, 3, 1'b0};
        tbl[5] = '{3, 3, 1'b0, 0, 1'b1};
        tbl[6] = '{16, 20, 1'b0, 16, 1'b0};
        tbl[7] = '{32, 32, 1'b0, 31, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bitlen", bit_length, 867);
        chk("rst_valid", longint'(bit_length_valid), 0);
        chk("rst_locked", longint'(locked), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_hold", longint'(rx_hold), 0);
        chk("rst_tout", longint'(timeout_err), 0);
        chk("rst_range", longint'(range_err), 0);
        $display("reset: bit_length=%0d busy=%0b", bit_length, busy);

        // Arm together with abort in IDLE: abort wins
        @(posedge clk); #1 arm = 1'b1; abort_req = 1'b1;
        @(posedge clk); #1 arm = 1'b0; abort_req = 1'b0;
        @(negedge clk);
        chk("arm_abort_busy", longint'(busy), 0);
        $display("arm+abort: busy=%0b", busy);

        // Start edge then line held low: measurement phase times out
        v0 = valid_count;
        pulse_arm();
        drive_seg(1'b1, 30);
        @(posedge clk); #1 rx = 1'b0;
        repeat (990) @(negedge clk);
        chk("tout_early", longint'(timeout_err), 0);
        chk("tout_busy", longint'(busy), 1);
        found = 1'b0;
        c     = 990;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c++;
            if (timeout_err) begin
                found = 1'b1;
                break;
            end
        end
        chk("tout_fired", longint'(found), 1);
        chk_range("tout_clks", c, 995, 1015);
        chk("tout_bitlen", bit_length, 867);
        chk("tout_locked", longint'(locked), 0);
        chk("tout_range", longint'(range_err), 0);
        @(posedge clk); #1 rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("tout_valid", valid_count - v0, 0);
`ifdef UART_AUTOBAUD_RETRY_EN
        pulse_abort();
`else
        chk("tout_idle", longint'(busy), 0);
`endif
        $display("timeout: after %0d clks timeout_err=%0b bit_length=%0d", c, timeout_err, bit_length);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("tbl%0d", i), tbl[i].bit_clks, tbl[i].start_clks, tbl[i].jit,
                    1'b0, tbl[i].exp_bl, tbl[i].exp_err);
        end

        // Randomized characters against the reference model
        for (int i = 0; i < 6; i++) begin
            int b, st;
            b  = int'($urandom_range(100, 4));
            st = b + int'($urandom_range(b)) - b / 2;
            run_vec($sformatf("rnd%0d", i), b, st, 1'b1, 1'b1, 0, 1'b0);
        end

        // Abort during MEASURE
        v0 = valid_count;
        pulse_arm();
        drive_seg(1'b1, 30);
        drive_seg(1'b0, 16);
        drive_seg(1'b1, 16);
        drive_seg(1'b0, 8);
        chk("abort_busy_before", longint'(busy), 1);
        pulse_abort();
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_range", longint'(range_err), 0);
        chk("abort_tout", longint'(timeout_err), 0);
        chk("abort_locked", longint'(locked), 0);
        chk("abort_bitlen", bit_length, cur_bl);
        @(posedge clk); #1 rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_valid", valid_count - v0, 0);
        $display("abort: busy=%0b bit_length=%0d", busy, bit_length);

        // Reset during MEASURE
        pulse_arm();
        drive_seg(1'b1, 30);
        drive_seg(1'b0, 16);
        drive_seg(1'b1, 16);
        drive_seg(1'b0, 5);
        chk("mrst_busy_before", longint'(busy), 1);
        @(posedge clk); #1 rst = 1'b1; rx = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_bitlen", bit_length, 867);
        chk("mrst_busy", longint'(busy), 0);
        chk("mrst_hold", longint'(rx_hold), 0);
        chk("mrst_locked", longint'(locked), 0);
        chk("mrst_range", longint'(range_err), 0);
        chk("mrst_tout", longint'(timeout_err), 0);
        cur_bl = 867;
        $display("reset mid-measure: bit_length=%0d busy=%0b", bit_length, busy);

`ifdef UART_AUTOBAUD_RETRY_EN
        // Bad character, then a good one with no second arm
        pulse_arm();
        drive_seg(1'b1, 30);
        make_durs(2, 2, 1'b0);
        drive_char();
        drive_seg(1'b1, 30);
        chk("retry_range", longint'(range_err), 1);
        chk("retry_busy", longint'(busy), 1);
        make_durs(32, 32, 1'b0);
        drive_char();
        wait_event(1'b1, c, found);
        chk("retry_done", longint'(found), 1);
        repeat (2) @(negedge clk);
        chk("retry_bitlen", bit_length, 31);
        chk("retry_locked", longint'(locked), 1);
        chk("retry_range_sticky", longint'(range_err), 1);
        chk("retry_idle", longint'(busy), 0);
        $display("retry: bit_length=%0d locked=%0b range_err=%0b", bit_length, locked, range_err);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
